// File: rtl/fib_stream_checker.sv
// Fibonacci term stream checker: samples strobed terms, verifies each equals the
// modulo-2^WIDTH sum of the previous two, and reports pass/wrap pulses plus a sticky first error.
module fib_stream_checker #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int STRICT_SEED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             ok,
    output logic             err,
    output logic [CNT_W-1:0] err_index,
    output logic [WIDTH-1:0] err_got,
    output logic [WIDTH-1:0] err_exp,
    output logic             wrap,
    output logic [CNT_W-1:0] term_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        SEED0 = 2'd0,
        SEED1 = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] SEED0_VAL = WIDTH'(0);
    localparam logic [WIDTH-1:0] SEED1_VAL = WIDTH'(1);
    localparam logic             STRICT    = (STRICT_SEED != 0);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev0_q, prev0_d;
    logic [WIDTH-1:0]   prev1_q, prev1_d;
    logic [CNT_W-1:0]   term_count_q, term_count_d;
    logic [CNT_W-1:0]   err_index_q, err_index_d;
    logic [WIDTH-1:0]   err_got_q, err_got_d;
    logic [WIDTH-1:0]   err_exp_q, err_exp_d;
    logic               ok_q, ok_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   expected;
    logic               carry;
    logic [CNT_W-1:0]   count_inc;

    assign sum      = {1'b0, prev0_q} + {1'b0, prev1_q};
    assign expected = sum[WIDTH-1:0];
    assign carry    = sum[WIDTH];

    // Counter sticks at all-ones rather than wrapping back to zero.
    assign count_inc = (term_count_q == {CNT_W{1'b1}}) ? term_count_q
                                                       : term_count_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        prev0_d      = prev0_q;
        prev1_d      = prev1_q;
        term_count_d = term_count_q;
        err_index_d  = err_index_q;
        err_got_d    = err_got_q;
        err_exp_d    = err_exp_q;
        ok_d         = 1'b0;
        wrap_d       = 1'b0;

        if (restart) begin
            state_d      = SEED0;
            prev0_d      = '0;
            prev1_d      = '0;
            term_count_d = '0;
            err_index_d  = '0;
            err_got_d    = '0;
            err_exp_d    = '0;
        end else if (in_valid) begin
            case (state_q)
                SEED0: begin
                    prev0_d      = in_data;
                    term_count_d = count_inc;
                    if (STRICT && (in_data != SEED0_VAL)) begin
                        state_d     = FAIL;
                        err_index_d = CNT_W'(0);
                        err_got_d   = in_data;
                        err_exp_d   = SEED0_VAL;
                    end else begin
                        state_d = SEED1;
                        ok_d    = 1'b1;
                    end
                end
                SEED1: begin
                    prev1_d      = prev0_q;
                    prev0_d      = in_data;
                    term_count_d = count_inc;
                    if (STRICT && (in_data != SEED1_VAL)) begin
                        state_d     = FAIL;
                        err_index_d = CNT_W'(1);
                        err_got_d   = in_data;
                        err_exp_d   = SEED1_VAL;
                    end else begin
                        state_d = CHECK;
                        ok_d    = 1'b1;
                    end
                end
                CHECK: begin
                    if (in_data == expected) begin
                        prev1_d      = prev0_q;
                        prev0_d      = in_data;
                        term_count_d = count_inc;
                        ok_d         = 1'b1;
                        wrap_d       = carry;
                    end else begin
                        // History is frozen so the failing context stays inspectable.
                        state_d     = FAIL;
                        err_index_d = term_count_q;
                        err_got_d   = in_data;
                        err_exp_d   = expected;
                    end
                end
                default: begin
                    state_d = FAIL;
                end
            endcase
        end

        err_d  = (state_d == FAIL);
        busy_d = (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEED0;
            prev0_q      <= '0;
            prev1_q      <= '0;
            term_count_q <= '0;
            err_index_q  <= '0;
            err_got_q    <= '0;
            err_exp_q    <= '0;
            ok_q         <= 1'b0;
            wrap_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev0_q      <= prev0_d;
            prev1_q      <= prev1_d;
            term_count_q <= term_count_d;
            err_index_q  <= err_index_d;
            err_got_q    <= err_got_d;
            err_exp_q    <= err_exp_d;
            ok_q         <= ok_d;
            wrap_q       <= wrap_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign ok         = ok_q;
    assign wrap       = wrap_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign err_index  = err_index_q;
    assign err_got    = err_got_q;
    assign err_exp    = err_exp_q;
    assign term_count = term_count_q;

endmodule
